// File: rtl/mmc_pkg.sv
// Shared definitions for the MMC CMD-line capture block.
//  - token lengths, synchroniser depth and counter/packet widths
//  - FSM state encoding (also exported on debug_state)
//  - command indices whose response is a 136-bit R2 token
package mmc_pkg;

   localparam int MMC_SHORT_LEN   = 48;
   localparam int MMC_LONG_LEN    = 136;
   localparam int MMC_SYNC_STAGES = 2;
   localparam int MMC_CNT_W       = 9;
   localparam int MMC_PKT_W       = 48;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_TRANS  = 3'd1,
      ST_BODY   = 3'd2,
      ST_ENDCHK = 3'd3,
      ST_VALID  = 3'd4
   } mmc_state_e;

   // CMD2 (ALL_SEND_CID), CMD9 (SEND_CSD), CMD10 (SEND_CID) are answered with R2.
   localparam logic [5:0] MMC_CMD_ALL_SEND_CID = 6'd2;
   localparam logic [5:0] MMC_CMD_SEND_CSD     = 6'd9;
   localparam logic [5:0] MMC_CMD_SEND_CID     = 6'd10;

   function automatic logic is_r2_trigger(input logic [5:0] idx);
      return (idx == MMC_CMD_ALL_SEND_CID) ||
             (idx == MMC_CMD_SEND_CSD)     ||
             (idx == MMC_CMD_SEND_CID);
   endfunction

endpackage

// File: rtl/mmc_edge_sync.sv
// Synchroniser and rising-edge detector for the MMC bus pins.
//  clk       in  system clock
//  reset_i   in  synchronous active-high reset
//  mmc_clk   in  MMC bus clock, asynchronous
//  mmc_cmd   in  MMC CMD line, asynchronous
//  bit_event out one-clk strobe on a rise of the synchronised mmc_clk
//  cmd_bit   out synchronised mmc_cmd, aligned with bit_event
module mmc_edge_sync
   import mmc_pkg::*;
#(
   parameter int STAGES = MMC_SYNC_STAGES
) (
   input  logic clk,
   input  logic reset_i,
   input  logic mmc_clk,
   input  logic mmc_cmd,
   output logic bit_event,
   output logic cmd_bit
);

   // Both pins travel through identical chains so cmd stays aligned with the clock edge
   // it was launched against.
   logic [STAGES-1:0] clk_sync;
   logic [STAGES-1:0] cmd_sync;
   logic              clk_prev;

   // NOTE: reset is sampled on the clock edge (synchronous); flops preset to 1 model an idle
   // bus so leaving reset with mmc_clk high produces no false edge.
   always_ff @(posedge clk) begin
      if (reset_i) begin
         clk_sync <= '1;
         cmd_sync <= '1;
         clk_prev <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments make every flop sample the pre-edge values, which
         // is what turns this chain into a shift register rather than a wire.
         clk_sync <= {clk_sync[STAGES-2:0], mmc_clk};
         cmd_sync <= {cmd_sync[STAGES-2:0], mmc_cmd};
         clk_prev <= clk_sync[STAGES-1];
      end
   end

   assign bit_event = clk_sync[STAGES-1] & ~clk_prev;
   assign cmd_bit   = cmd_sync[STAGES-1];

endmodule

// File: rtl/mmc_cmd_msg_capture.sv
// Passive MMC/SD CMD-line sniffer. Frames 48-bit tokens and 136-bit R2 tokens and
// presents the final 48 bits of each well-framed token with a one-cycle strobe.
//  clk          in   system clock (>= 2x mmc_clk)
//  reset_i      in   synchronous active-high reset
//  mmc_clk      in   MMC bus clock, asynchronous
//  mmc_cmd      in   MMC CMD line, asynchronous
//  msg_packet   out  last 48 bits of the most recent valid token, first bit at MSB
//  msg_valid    out  one-clk strobe, msg_packet carries a new token
//  debug_state  out  FSM state
//  debug_cnt    out  bits received in the current token
module mmc_cmd_msg_capture
   import mmc_pkg::*;
#(
   parameter int SHORT_LEN   = MMC_SHORT_LEN,
   parameter int LONG_LEN    = MMC_LONG_LEN,
   parameter int SYNC_STAGES = MMC_SYNC_STAGES
) (
   input  logic                 clk,
   input  logic                 reset_i,
   input  logic                 mmc_clk,
   input  logic                 mmc_cmd,
   output logic [MMC_PKT_W-1:0] msg_packet,
   output logic                 msg_valid,
   output logic [2:0]           debug_state,
   output logic [MMC_CNT_W-1:0] debug_cnt
);

   logic                 bit_event;
   logic                 cmd_bit;
   mmc_state_e           state, state_nxt;
   logic [MMC_CNT_W-1:0] cnt, cnt_nxt, cnt_inc, tok_len;
   logic [MMC_PKT_W-1:0] shreg;
   logic                 long_pending, lp_nxt;
   logic                 shift_en;
   logic                 capture;

   mmc_edge_sync #(
      .STAGES (SYNC_STAGES)
   ) u_edge_sync (
      .clk       (clk),
      .reset_i   (reset_i),
      .mmc_clk   (mmc_clk),
      .mmc_cmd   (mmc_cmd),
      .bit_event (bit_event),
      .cmd_bit   (cmd_bit)
   );

   assign tok_len = long_pending ? MMC_CNT_W'(LONG_LEN) : MMC_CNT_W'(SHORT_LEN);
   assign cnt_inc = cnt + 1'b1;

   always_ff @(posedge clk) begin
      if (reset_i) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   // NOTE: every output of this block gets a default before the case, so no path leaves a
   // signal unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      lp_nxt    = long_pending;
      shift_en  = 1'b0;
      capture   = 1'b0;
      case (state)
         ST_IDLE: begin
            cnt_nxt = '0;
            if (bit_event && !cmd_bit) begin
               shift_en  = 1'b1;
               cnt_nxt   = MMC_CNT_W'(1);
               state_nxt = ST_TRANS;
            end
         end
         ST_TRANS: begin
            if (bit_event) begin
               shift_en  = 1'b1;
               cnt_nxt   = MMC_CNT_W'(2);
               state_nxt = ST_BODY;
            end
         end
         ST_BODY: begin
            if (bit_event) begin
               shift_en = 1'b1;
               cnt_nxt  = cnt_inc;
               if (cnt_inc == tok_len - 1'b1) state_nxt = ST_ENDCHK;
            end
         end
         ST_ENDCHK: begin
            if (bit_event) begin
               shift_en = 1'b1;
               cnt_nxt  = tok_len;
               if (cmd_bit) begin
                  state_nxt = ST_VALID;
               end else begin
                  // Framing error ends the token just the same, so an R2 expectation is dropped.
                  lp_nxt    = 1'b0;
                  state_nxt = ST_IDLE;
               end
            end
         end
         ST_VALID: begin
            capture   = 1'b1;
            // A long token consumes the pending flag; only a short token can arm it.
            lp_nxt    = !long_pending && is_r2_trigger(shreg[45:40]);
            state_nxt = ST_IDLE;
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset_i) begin
         cnt          <= '0;
         shreg        <= '0;
         long_pending <= 1'b0;
         msg_packet   <= '0;
         msg_valid    <= 1'b0;
      end else begin
         cnt          <= cnt_nxt;
         long_pending <= lp_nxt;
         msg_valid    <= capture;
         if (shift_en) shreg <= {shreg[MMC_PKT_W-2:0], cmd_bit};
         // Packet and strobe are registered together so a consumer sees them in the same cycle.
         if (capture) msg_packet <= shreg;
      end
   end

   assign debug_state = state;
   assign debug_cnt   = cnt;

endmodule

// File: tb/tb_mmc_cmd_msg_capture.sv
// Self-checking bench for mmc_cmd_msg_capture: directed token table, reset corner case
// and randomized tokens scored against a token-level reference model.
module tb_mmc_cmd_msg_capture;

   logic        clk = 1'b0;
   logic        reset_i = 1'b1;
   logic        mmc_clk = 1'b0;
   logic        mmc_cmd = 1'b1;
   logic [47:0] msg_packet;
   logic        msg_valid;
   logic [2:0]  debug_state;
   logic [8:0]  debug_cnt;

   int total = 0;
   int bad   = 0;
   int strobe_cnt = 0;
   int cnt_peak = 0;

   mmc_cmd_msg_capture dut (
      .clk         (clk),
      .reset_i     (reset_i),
      .mmc_clk     (mmc_clk),
      .mmc_cmd     (mmc_cmd),
      .msg_packet  (msg_packet),
      .msg_valid   (msg_valid),
      .debug_state (debug_state),
      .debug_cnt   (debug_cnt)
   );

   always #5 clk = ~clk;

   // Observe on the falling clk edge, half a cycle away from where the DUT updates.
   always @(negedge clk) begin
      if (msg_valid) strobe_cnt = strobe_cnt + 1;
      if (int'(debug_cnt) > cnt_peak) cnt_peak = int'(debug_cnt);
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total = total + 1;
      if (got !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endtask

   // Bus edges are kept at times congruent to 2 mod 5 ns, never on a clk edge.
   task automatic send_bit(input logic b, input int hp);
      mmc_cmd = b;
      #(hp) mmc_clk = 1'b1;
      #(hp) mmc_clk = 1'b0;
   endtask

   typedef struct {
      string          name;
      logic [135:0]   bits;    // bit n-1 is sent first
      int             n;
      logic           exp_valid;
      logic [47:0]    exp_pkt;
      int             exp_peak;
   } vec_t;

   function automatic logic [135:0] rand_bits();
      logic [135:0] r;
      for (int i = 0; i < 136; i++) r[i] = 1'($urandom_range(0, 1));
      return r;
   endfunction

   task automatic run_token(input vec_t v, input int hp);
      int s0;
      s0 = strobe_cnt;
      cnt_peak = 0;
      for (int i = v.n - 1; i >= 1; i--) send_bit(v.bits[i], hp);
      check({v.name, "/early_strobe"}, 64'(strobe_cnt - s0), 64'd0);
      send_bit(v.bits[0], hp);
      mmc_cmd = 1'b1;
      #100;
      check({v.name, "/strobes"}, 64'(strobe_cnt - s0), 64'(v.exp_valid));
      check({v.name, "/packet"},  64'(msg_packet), 64'(v.exp_pkt));
      check({v.name, "/cnt_peak"}, 64'(cnt_peak), 64'(v.exp_peak));
      check({v.name, "/state"},   64'(debug_state), 64'd0);
   endtask

   // Token-level reference model: expected length follows the pending-R2 flag, a token is
   // accepted iff its last bit is 1, and only an accepted short CMD2/9/10 arms the flag.
   logic        model_lp  = 1'b0;
   logic [47:0] model_pkt = '0;

   task automatic model_token(input vec_t v_in, output vec_t v_out);
      logic [5:0] idx;
      v_out = v_in;
      v_out.exp_peak = v_in.n;
      idx = v_in.bits[45:40];
      if (v_in.bits[0]) begin
         v_out.exp_valid = 1'b1;
         model_pkt = v_in.bits[47:0];
         model_lp  = !model_lp && (idx == 6'd2 || idx == 6'd9 || idx == 6'd10);
      end else begin
         v_out.exp_valid = 1'b0;
         model_lp = 1'b0;
      end
      v_out.exp_pkt = model_pkt;
   endtask

   vec_t tbl[5];

   initial begin
      vec_t v, e;
      logic [135:0] r;
      int hp;

      // ---- directed table ----
      tbl[0].name = "all_zero_body";
      tbl[0].bits = '0; tbl[0].bits[46] = 1'b1; tbl[0].bits[0] = 1'b1;
      tbl[0].n = 48; tbl[0].exp_valid = 1'b1;
      tbl[0].exp_pkt = 48'h4000_0000_0001; tbl[0].exp_peak = 48;

      r = rand_bits();
      tbl[1].name = "cmd2";
      tbl[1].bits = '0;
      tbl[1].bits[47:0] = {1'b0, 1'b1, 6'd2, r[38:0], 1'b1};
      tbl[1].n = 48; tbl[1].exp_valid = 1'b1;
      tbl[1].exp_pkt = tbl[1].bits[47:0]; tbl[1].exp_peak = 48;

      tbl[2].name = "r2_long";
      tbl[2].bits = rand_bits();
      tbl[2].bits[135] = 1'b0; tbl[2].bits[134] = 1'b1; tbl[2].bits[0] = 1'b1;
      tbl[2].n = 136; tbl[2].exp_valid = 1'b1;
      tbl[2].exp_pkt = tbl[2].bits[47:0]; tbl[2].exp_peak = 136;

      tbl[3].name = "short_after_r2";
      tbl[3].bits = rand_bits();
      tbl[3].bits[47] = 1'b0; tbl[3].bits[45:40] = 6'd17; tbl[3].bits[0] = 1'b1;
      tbl[3].n = 48; tbl[3].exp_valid = 1'b1;
      tbl[3].exp_pkt = tbl[3].bits[47:0]; tbl[3].exp_peak = 48;

      tbl[4].name = "framing_error";
      tbl[4].bits = rand_bits();
      tbl[4].bits[47] = 1'b0; tbl[4].bits[45:40] = 6'd2; tbl[4].bits[0] = 1'b0;
      tbl[4].n = 48; tbl[4].exp_valid = 1'b0;
      tbl[4].exp_pkt = tbl[3].bits[47:0]; tbl[4].exp_peak = 48;

      // ---- reset ----
      #2;
      #40 reset_i = 1'b0;
      #20;
      check("reset/packet", 64'(msg_packet), 64'd0);
      check("reset/valid",  64'(msg_valid), 64'd0);
      check("reset/state",  64'(debug_state), 64'd0);
      check("reset/cnt",    64'(debug_cnt), 64'd0);

      // ---- idle bus ----
      strobe_cnt = 0;
      cnt_peak = 0;
      for (int i = 0; i < 6; i++) send_bit(1'b1, 10);
      #50;
      check("idle/strobes", 64'(strobe_cnt), 64'd0);
      check("idle/cnt_peak", 64'(cnt_peak), 64'd0);
      check("idle/state", 64'(debug_state), 64'd0);

      // ---- table ----
      for (int i = 0; i < 5; i++) begin
         run_token(tbl[i], 10);
         if (i == 1) begin
            check("cmd2/top_byte", 64'(msg_packet[47:40]), 64'h42);
            check("cmd2/lsb", 64'(msg_packet[0]), 64'd1);
         end
      end
      model_lp  = 1'b0;
      model_pkt = tbl[3].bits[47:0];

      // ---- reset in the middle of a token ----
      v.bits = rand_bits();
      v.bits[135] = 1'b0;
      for (int i = 135; i > 115; i--) send_bit(v.bits[i], 10);
      reset_i = 1'b1;
      #30;
      check("midreset/packet", 64'(msg_packet), 64'd0);
      check("midreset/valid",  64'(msg_valid), 64'd0);
      check("midreset/state",  64'(debug_state), 64'd0);
      check("midreset/cnt",    64'(debug_cnt), 64'd0);
      reset_i = 1'b0;
      mmc_cmd = 1'b1;
      #40;
      model_lp  = 1'b0;
      model_pkt = '0;

      v.name = "after_reset";
      v.bits = rand_bits();
      v.bits[47] = 1'b0; v.bits[45:40] = 6'd9; v.bits[0] = 1'b1;
      v.n = 48;
      model_token(v, e);
      run_token(e, 10);

      // ---- randomized tokens against the model ----
      for (int t = 0; t < 24; t++) begin
         v.name = $sformatf("rand%0d", t);
         v.n = model_lp ? 136 : 48;
         v.bits = rand_bits();
         v.bits[v.n - 1] = 1'b0;
         if (!model_lp && $urandom_range(0, 2) == 0) begin
            case ($urandom_range(0, 2))
               0:       v.bits[45:40] = 6'd2;
               1:       v.bits[45:40] = 6'd9;
               default: v.bits[45:40] = 6'd10;
            endcase
         end
         v.bits[0] = ($urandom_range(0, 7) != 0);
         hp = 5 * int'($urandom_range(2, 4));
         model_token(v, e);
         run_token(e, hp);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
